pipe_decode_fwd: RTL and testbench
==================================

PIPE_DECODE_FWD -- requirements
Module: pipe_decode_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 64, register and data width in bits.
REQ-002 SHALL have parameter FWD_EN, default 1; 1 = forwarding network enabled, 0 = register-file read only.
REQ-003 SHALL have parameter RSP_ID, default 4'h4, stack pointer register index.
REQ-004 SHALL have port clk, input, 1, single clock, all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset sampled on rising clk.
REQ-006 SHALL have port D_icode / D_ifun / D_rA / D_rB, input, 4 each, fetched instruction fields.
REQ-007 SHALL have port D_valC / D_valP, input, XLEN each, constant word and next PC.
REQ-008 SHALL have port stall / bubble, input, 1 each, pipeline control from the hazard unit.
REQ-009 SHALL have port e_dstE / e_valE, input, 4 / XLEN, execute-stage result (dstE already cnd-qualified).
REQ-010 SHALL have ports M_dstE / M_valE / M_dstM / m_valM, input, 4/XLEN/4/XLEN, memory-stage results.
REQ-011 SHALL have ports W_dstE / W_valE / W_dstM / W_valM, input, 4/XLEN/4/XLEN, writeback ports into internal register file.
REQ-012 SHALL have port E_icode / E_ifun, output, 4 each, registered instruction fields.
REQ-013 SHALL have ports E_valA / E_valB / E_valC, output, XLEN each, registered operands.
REQ-014 SHALL have ports E_srcA / E_srcB / E_dstE / E_dstM, output, 4 each, registered register IDs; 4'hF = none.
REQ-015 SHALL have port load_use, output, 1, combinational load/use hazard flag.

Function
REQ-016 SHALL hold 15 XLEN-bit registers (IDs 0..14); ID 4'hF SHALL read as zero and ignore writes.
REQ-017 srcA SHALL be rA for icode 2,4,6,A; RSP_ID for 9,B; else 4'hF.
REQ-018 srcB SHALL be rB for icode 4,5,6; RSP_ID for 8,9,A,B; else 4'hF.
REQ-019 dstE SHALL be rB for icode 2,3,6; RSP_ID for 8,9,A,B; else 4'hF (cmov condition resolved in execute, not here).
REQ-020 dstM SHALL be rA for icode 5,B; else 4'hF.
REQ-021 valA SHALL be D_valP for icode 7 and 8, regardless of srcA.
REQ-022 With FWD_EN=1, a source ID != 4'hF SHALL select first match in priority: e_dstE, M_dstM, M_dstE, W_dstM, W_dstE, then register file.
REQ-023 With FWD_EN=0, operands SHALL come from the register file only; writes in the same cycle SHALL NOT bypass.
REQ-024 Register file writes SHALL occur on rising clk; W_dstM write SHALL win over W_dstE when both target the same ID.
REQ-025 load_use SHALL be 1 when E_icode is 5 or B and E_dstM != 4'hF equals srcA or srcB; else 0.
REQ-026 Pipeline register latency SHALL be one cycle: D fields captured on rising clk appear on E_* next cycle.
REQ-027 bubble=1 SHALL load nop (icode 1, ifun 0, IDs 4'hF, values 0) into E_*.
REQ-028 stall=1 with bubble=0 SHALL hold E_*; bubble SHALL take priority when both asserted.
REQ-029 Register file writes SHALL proceed during stall and bubble.

Reset
REQ-030 reset=1 SHALL load the nop bubble of REQ-027 into all E_* outputs on the next rising clk.
REQ-031 reset=1 SHALL clear all register-file entries to 0, overriding same-cycle W writes; reset mid-operation SHALL discard in-flight E contents.
REQ-032 load_use SHALL be 0 in the cycle after reset.

Verification
REQ-033 Reset, then D_icode=3, rB=2, valC=0x10 -> next cycle E_dstE=2, E_valC=0x10, E_srcA=E_srcB=4'hF.
REQ-034 W_dstE=3, W_valE=0x55; next cycle D_icode=6, rA=3, rB=3 -> E_valA=E_valB=0x55.
REQ-035 Simultaneous e_dstE=1/0xAA and W_dstE=1/0xBB, D_icode=2, rA=1 -> E_valA=0xAA (FWD_EN=1); 0x0 from file (FWD_EN=0).
REQ-036 E holds mrmovq (icode 5) with dstM=7; D_icode=6, rA=7 -> load_use=1; with stall=1 E_* unchanged.
REQ-037 D_icode=8 (call), valP=0x40 -> E_valA=0x40, E_srcB=E_dstE=4'h4.
REQ-038 stall=1 and bubble=1 together -> E_icode=1, all E IDs 4'hF.

Source files
------------

// File: rtl/pipe_decode_fwd.sv
// Decode stage: register file, source/destination selection, operand
// forwarding and the D->E pipeline register with stall/bubble control.
module pipe_decode_fwd #(
  parameter int         XLEN   = 64,
  parameter bit         FWD_EN = 1'b1,
  parameter logic [3:0] RSP_ID = 4'h4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [3:0]      D_rA,
  input  logic [3:0]      D_rB,
  input  logic [XLEN-1:0] D_valC,
  input  logic [XLEN-1:0] D_valP,
  input  logic            stall,
  input  logic            bubble,
  input  logic [3:0]      e_dstE,
  input  logic [XLEN-1:0] e_valE,
  input  logic [3:0]      M_dstE,
  input  logic [XLEN-1:0] M_valE,
  input  logic [3:0]      M_dstM,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      W_dstE,
  input  logic [XLEN-1:0] W_valE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] W_valM,
  output logic [3:0]      E_icode,
  output logic [3:0]      E_ifun,
  output logic [XLEN-1:0] E_valA,
  output logic [XLEN-1:0] E_valB,
  output logic [XLEN-1:0] E_valC,
  output logic [3:0]      E_srcA,
  output logic [3:0]      E_srcB,
  output logic [3:0]      E_dstE,
  output logic [3:0]      E_dstM,
  output logic            load_use
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [XLEN-1:0] rf [0:14];
  logic [3:0]      src_a, src_b, dst_e, dst_m;
  logic [XLEN-1:0] rd_a, rd_b, val_a, val_b;

  // Register file: ID F is never stored; dstM is written last so it wins a tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      if (W_dstE != RNONE) rf[W_dstE] <= W_valE;
      if (W_dstM != RNONE) rf[W_dstM] <= W_valM;
    end
  end

  // Source and destination IDs from the instruction class.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      4'h2: begin src_a = D_rA;   dst_e = D_rB; end
      4'h3: begin                 dst_e = D_rB; end
      4'h4: begin src_a = D_rA;   src_b = D_rB; end
      4'h5: begin src_b = D_rB;   dst_m = D_rA; end
      4'h6: begin src_a = D_rA;   src_b = D_rB; dst_e = D_rB; end
      4'h8: begin src_b = RSP_ID; dst_e = RSP_ID; end
      4'h9: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
      4'hA: begin src_a = D_rA;   src_b = RSP_ID; dst_e = RSP_ID; end
      4'hB: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = D_rA; end
      default: ;
    endcase
  end

  assign rd_a = (src_a == RNONE) ? '0 : rf[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : rf[src_b];

  // Operand A: call/jump carry valP; otherwise youngest in-flight producer wins.
  always_comb begin
    val_a = rd_a;
    if (D_icode == 4'h7 || D_icode == 4'h8) val_a = D_valP;
    else if (FWD_EN && src_a != RNONE) begin
      if      (e_dstE == src_a) val_a = e_valE;
      else if (M_dstM == src_a) val_a = m_valM;
      else if (M_dstE == src_a) val_a = M_valE;
      else if (W_dstM == src_a) val_a = W_valM;
      else if (W_dstE == src_a) val_a = W_valE;
    end
  end

  // Operand B: same forwarding priority as A.
  always_comb begin
    val_b = rd_b;
    if (FWD_EN && src_b != RNONE) begin
      if      (e_dstE == src_b) val_b = e_valE;
      else if (M_dstM == src_b) val_b = m_valM;
      else if (M_dstE == src_b) val_b = M_valE;
      else if (W_dstM == src_b) val_b = W_valM;
      else if (W_dstE == src_b) val_b = W_valE;
    end
  end

  // D->E pipeline register: reset/bubble inject a nop, stall holds.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= 4'h0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
    end else if (!stall) begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_valC  <= D_valC;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
    end
  end

  assign load_use = (E_icode == I_MRMOV || E_icode == I_POP) && (E_dstM != RNONE) &&
                    (E_dstM == src_a || E_dstM == src_b);

endmodule

// File: tb/tb_pipe_decode_fwd.sv
// Bench for pipe_decode_fwd: one forwarding and one file-only instance
// share stimulus and are compared against a behavioural decode model.
module tb_pipe_decode_fwd;

  typedef struct packed {
    logic [3:0]  icode, ifun, srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, valC;
  } e_t;

  localparam e_t NOP = '{icode: 4'h1, ifun: 4'h0, srcA: 4'hF, srcB: 4'hF,
                         dstE: 4'hF, dstM: 4'hF, valA: 64'h0, valB: 64'h0, valC: 64'h0};

  logic clk = 1'b0;
  logic reset, stall, bubble;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;

  logic [3:0]  f_icode, f_ifun, f_srcA, f_srcB, f_dstE, f_dstM;
  logic [63:0] f_valA, f_valB, f_valC;
  logic        f_lu;
  logic [3:0]  r_icode, r_ifun, r_srcA, r_srcB, r_dstE, r_dstM;
  logic [63:0] r_valA, r_valB, r_valC;
  logic        r_lu;

  e_t act_f, act_r, exp_f, exp_r;
  logic [63:0] m_rf [0:14];
  int n_cmp = 0;
  int n_err = 0;

  assign act_f = {f_icode, f_ifun, f_srcA, f_srcB, f_dstE, f_dstM, f_valA, f_valB, f_valC};
  assign act_r = {r_icode, r_ifun, r_srcA, r_srcB, r_dstE, r_dstM, r_valA, r_valB, r_valC};

  always #5 clk = ~clk;

  pipe_decode_fwd #(.XLEN(64), .FWD_EN(1'b1), .RSP_ID(4'h4)) dut_fwd (
    .clk(clk), .reset(reset), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .stall(stall), .bubble(bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .E_icode(f_icode), .E_ifun(f_ifun), .E_valA(f_valA), .E_valB(f_valB), .E_valC(f_valC),
    .E_srcA(f_srcA), .E_srcB(f_srcB), .E_dstE(f_dstE), .E_dstM(f_dstM), .load_use(f_lu));

  pipe_decode_fwd #(.XLEN(64), .FWD_EN(1'b0), .RSP_ID(4'h4)) dut_rf (
    .clk(clk), .reset(reset), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .stall(stall), .bubble(bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .E_icode(r_icode), .E_ifun(r_ifun), .E_valA(r_valA), .E_valB(r_valB), .E_valC(r_valC),
    .E_srcA(r_srcA), .E_srcB(r_srcB), .E_dstE(r_dstE), .E_dstM(r_dstM), .load_use(r_lu));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_e(input string p, input e_t got, input e_t exp);
    check({p, "_icode"}, 64'(got.icode), 64'(exp.icode));
    check({p, "_ifun"},  64'(got.ifun),  64'(exp.ifun));
    check({p, "_srcA"},  64'(got.srcA),  64'(exp.srcA));
    check({p, "_srcB"},  64'(got.srcB),  64'(exp.srcB));
    check({p, "_dstE"},  64'(got.dstE),  64'(exp.dstE));
    check({p, "_dstM"},  64'(got.dstM),  64'(exp.dstM));
    check({p, "_valA"},  got.valA, exp.valA);
    check({p, "_valB"},  got.valB, exp.valB);
    check({p, "_valC"},  got.valC, exp.valC);
  endtask

  // Instruction-class rules for register usage.
  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction
  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] m_opnd(input logic [3:0] id, input bit fwd);
    if (id == 4'hF) return 64'h0;
    if (fwd) begin
      if (e_dstE == id) return e_valE;
      if (M_dstM == id) return m_valM;
      if (M_dstE == id) return M_valE;
      if (W_dstM == id) return W_valM;
      if (W_dstE == id) return W_valE;
    end
    return m_rf[id];
  endfunction

  function automatic e_t m_next(input e_t cur, input bit fwd);
    e_t n;
    if (reset || bubble) return NOP;
    if (stall) return cur;
    n.icode = D_icode;
    n.ifun  = D_ifun;
    n.srcA  = m_srcA(D_icode, D_rA);
    n.srcB  = m_srcB(D_icode, D_rB);
    n.dstE  = m_dstE(D_icode, D_rB);
    n.dstM  = m_dstM(D_icode, D_rA);
    n.valC  = D_valC;
    n.valA  = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : m_opnd(n.srcA, fwd);
    n.valB  = m_opnd(n.srcB, fwd);
    return n;
  endfunction

  task automatic idle();
    reset = 1'b0; stall = 1'b0; bubble = 1'b0;
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = 4'hF; D_rB = 4'hF; D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  // One clock: check load_use before the edge, then E outputs after it.
  task automatic cycle();
    e_t nf, nr;
    logic lu;
    #1;
    lu = (exp_f.icode == 4'h5 || exp_f.icode == 4'hB) && exp_f.dstM != 4'hF &&
         (exp_f.dstM == m_srcA(D_icode, D_rA) || exp_f.dstM == m_srcB(D_icode, D_rB));
    check("load_use_fwd", 64'(f_lu), 64'(lu));
    check("load_use_rf",  64'(r_lu), 64'(lu));
    nf = m_next(exp_f, 1'b1);
    nr = m_next(exp_r, 1'b0);
    if (reset) for (int i = 0; i < 15; i++) m_rf[i] = '0;
    else begin
      if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
      if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
    end
    @(posedge clk);
    #1;
    exp_f = nf;
    exp_r = nr;
    check_e("E_fwd", act_f, exp_f);
    check_e("E_rf",  act_r, exp_r);
  endtask

  function automatic logic [3:0] rid();
    case ($urandom_range(0, 9))
      0:       return 4'hF;
      1:       return 4'($urandom_range(0, 14));
      default: return 4'($urandom_range(0, 5));
    endcase
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    W_dstE = 4'h3; W_valE = 64'hDEAD;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) m_rf[i] = '0;
    exp_f = NOP;
    exp_r = NOP;
    check_e("reset_fwd", act_f, NOP);
    check_e("reset_rf",  act_r, NOP);

    // Immediate-to-register move after reset; reset-overridden write stays lost.
    idle();
    D_icode = 4'h3; D_rA = 4'hF; D_rB = 4'h2; D_valC = 64'h10;
    cycle();
    check("irmov_dstE", 64'(f_dstE), 64'h2);
    check("irmov_valC", f_valC, 64'h10);
    check("irmov_srcA", 64'(f_srcA), 64'hF);
    check("irmov_srcB", 64'(f_srcB), 64'hF);

    // Write then read through the file.
    idle();
    W_dstE = 4'h3; W_valE = 64'h55;
    cycle();
    idle();
    D_icode = 4'h6; D_rA = 4'h3; D_rB = 4'h3;
    cycle();
    check("rf_valA_fwd", f_valA, 64'h55);
    check("rf_valB_fwd", f_valB, 64'h55);
    check("rf_valA_rf",  r_valA, 64'h55);

    // Execute forward beats writeback; file-only instance sees the old zero.
    idle();
    e_dstE = 4'h1; e_valE = 64'hAA; W_dstE = 4'h1; W_valE = 64'hBB;
    D_icode = 4'h2; D_rA = 4'h1; D_rB = 4'h0;
    cycle();
    check("prio_valA_fwd", f_valA, 64'hAA);
    check("nobypass_valA_rf", r_valA, 64'h0);

    // Load followed by a consumer, then stalled.
    idle();
    D_icode = 4'h5; D_rA = 4'h7; D_rB = 4'h0;
    cycle();
    idle();
    D_icode = 4'h6; D_rA = 4'h7; D_rB = 4'h0;
    #1;
    check("load_use_hit", 64'(f_lu), 64'h1);
    stall = 1'b1;
    cycle();
    check("stall_icode", 64'(f_icode), 64'h5);
    check("stall_dstM",  64'(f_dstM),  64'h7);

    // Call carries valP.
    idle();
    D_icode = 4'h8; D_valP = 64'h40; D_rA = 4'h9; D_rB = 4'h9;
    cycle();
    check("call_valA", f_valA, 64'h40);
    check("call_srcB", 64'(f_srcB), 64'h4);
    check("call_dstE", 64'(f_dstE), 64'h4);

    // Bubble wins over stall.
    idle();
    D_icode = 4'h6; D_rA = 4'h2; D_rB = 4'h3;
    stall = 1'b1; bubble = 1'b1;
    cycle();
    check("bub_icode", 64'(f_icode), 64'h1);
    check("bub_ids", 64'({f_srcA, f_srcB, f_dstE, f_dstM}), 64'hFFFF);

    for (int n = 0; n < 800; n++) begin
      reset   = ($urandom_range(0, 49) == 0);
      stall   = ($urandom_range(0, 7) == 0);
      bubble  = ($urandom_range(0, 11) == 0);
      D_icode = 4'($urandom_range(0, 11));
      D_ifun  = 4'($urandom_range(0, 15));
      D_rA    = rid();
      D_rB    = rid();
      D_valC  = r64();
      D_valP  = r64();
      e_dstE  = rid(); e_valE = r64();
      M_dstE  = rid(); M_valE = r64();
      M_dstM  = rid(); m_valM = r64();
      W_dstE  = rid(); W_valE = r64();
      W_dstM  = rid(); W_valM = r64();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
